// File: rtl/orion_types.sv
// Shared integer-core types: register-file geometry and writeback bundles.
// Provides XLEN, RF_IDX_BITS, NUM_REGS, NUM_WB_DEF and wb_req_t.
package orion_types;

    localparam int XLEN        = 32;
    localparam int RF_IDX_BITS = 5;
    localparam int NUM_REGS    = 32;
    localparam int NUM_WB_DEF  = 2;

    typedef struct packed {
        logic [RF_IDX_BITS-1:0] rd_s;
        logic [XLEN-1:0]        rd_v;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus from the execution units to rf_wb_arbiter.
// wb_valid/wb_req per requester (master drives), wb_ready per requester (slave drives).
interface rf_wb_arbiter_if
    import orion_types::*;
#(
    parameter int NUM_WB = NUM_WB_DEF
);

    logic    [NUM_WB-1:0] wb_valid;
    logic    [NUM_WB-1:0] wb_ready;
    wb_req_t [NUM_WB-1:0] wb_req;

    modport master (
        output wb_valid,
        output wb_req,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_req,
        output wb_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin: searches req_i from ptr_i upward (mod N).
// Ports: req_i request vector, ptr_i search start, gnt_o one-hot grant (or 0).
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin writeback scheduler for the register file write port, plus a
// pending-write scoreboard. Ports: clk_i/rst_i, wb (request bus, slave),
// sb_set_i/sb_set_idx_i (mark pending), busy_o, rf_we_o/rf_rd_s_o/rf_rd_v_o.
// Define ORION_WB_BYPASS_EN to add byp_valid_o/byp_rd_s_o/byp_rd_v_o and
// clear busy bits one cycle earlier.
module rf_wb_arbiter
    import orion_types::*;
#(
    parameter int NUM_WB = NUM_WB_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    rf_wb_arbiter_if.slave         wb,
    input  logic                   sb_set_i,
    input  logic [RF_IDX_BITS-1:0] sb_set_idx_i,
    output logic [NUM_REGS-1:0]    busy_o,
`ifdef ORION_WB_BYPASS_EN
    output logic                   byp_valid_o,
    output logic [RF_IDX_BITS-1:0] byp_rd_s_o,
    output logic [XLEN-1:0]        byp_rd_v_o,
`endif
    output logic                   rf_we_o,
    output logic [RF_IDX_BITS-1:0] rf_rd_s_o,
    output logic [XLEN-1:0]        rf_rd_v_o
);

    localparam int PW = (NUM_WB > 2) ? $clog2(NUM_WB) : 1;

    logic [PW-1:0]          ptr_q, ptr_d;
    logic [NUM_WB-1:0]      real_req, x0_req, gnt;
    logic                   gnt_any;
    logic [RF_IDX_BITS-1:0] gnt_rd;
    logic [XLEN-1:0]        gnt_v;
    logic                   rf_we_q;
    logic [RF_IDX_BITS-1:0] rf_rd_s_q;
    logic [XLEN-1:0]        rf_rd_v_q;
    logic [NUM_REGS-1:0]    busy_q, busy_d;
    logic                   clr_en;
    logic [RF_IDX_BITS-1:0] clr_idx;

    // x0 writes are swallowed here so they never compete for the port.
    always_comb begin
        real_req = '0;
        x0_req   = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            x0_req[k]   = wb.wb_valid[k] && (wb.wb_req[k].rd_s == '0);
            real_req[k] = wb.wb_valid[k] && (wb.wb_req[k].rd_s != '0);
        end
    end

    rr_arbiter #(
        .N  (NUM_WB),
        .PW (PW)
    ) u_rr (
        .req_i (real_req),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign wb.wb_ready = gnt | x0_req;

    always_comb begin
        gnt_any = 1'b0;
        gnt_rd  = '0;
        gnt_v   = '0;
        ptr_d   = ptr_q;
        for (int k = 0; k < NUM_WB; k++) begin
            if (gnt[k]) begin
                gnt_any = 1'b1;
                gnt_rd  = wb.wb_req[k].rd_s;
                gnt_v   = wb.wb_req[k].rd_v;
                ptr_d   = PW'((k + 1) % NUM_WB);
            end
        end
    end

`ifdef ORION_WB_BYPASS_EN
    // Consumers pick the value off the bypass, so retire at the grant edge.
    assign clr_en  = gnt_any;
    assign clr_idx = gnt_rd;
`else
    // Retire on the same edge the register file captures the write.
    assign clr_en  = rf_we_q;
    assign clr_idx = rf_rd_s_q;
`endif

    // Set is applied after clear so a re-issue on a retiring register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_idx] = 1'b0;
        end
        if (sb_set_i) begin
            busy_d[sb_set_idx_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q     <= '0;
            rf_we_q   <= 1'b0;
            rf_rd_s_q <= '0;
            rf_rd_v_q <= '0;
            busy_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            rf_we_q <= gnt_any;
            busy_q  <= busy_d;
            if (gnt_any) begin
                rf_rd_s_q <= gnt_rd;
                rf_rd_v_q <= gnt_v;
            end
        end
    end

    assign rf_we_o   = rf_we_q;
    assign rf_rd_s_o = rf_rd_s_q;
    assign rf_rd_v_o = rf_rd_v_q;
    assign busy_o    = busy_q;

`ifdef ORION_WB_BYPASS_EN
    assign byp_valid_o = rf_we_q;
    assign byp_rd_s_o  = rf_rd_s_q;
    assign byp_rd_v_o  = rf_rd_v_q;
`endif

    // Issue must never mark a register that is still pending, unless that
    // register is retiring on this very edge.
    a_no_double_set: assert property (
        @(posedge clk_i) disable iff (rst_i)
        (sb_set_i && (sb_set_idx_i != '0) &&
         !(clr_en && (clr_idx == sb_set_idx_i)))
        |-> !busy_q[sb_set_idx_i]
    );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter with two requesters.
// A cycle-level model predicts ready, writes (queued) and busy bits.
module tb_rf_wb_arbiter;
    import orion_types::*;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   sb_set_i;
    logic [RF_IDX_BITS-1:0] sb_set_idx_i;
    logic [NUM_REGS-1:0]    busy_o;
    logic                   rf_we_o;
    logic [RF_IDX_BITS-1:0] rf_rd_s_o;
    logic [XLEN-1:0]        rf_rd_v_o;
`ifdef ORION_WB_BYPASS_EN
    logic                   byp_valid_o;
    logic [RF_IDX_BITS-1:0] byp_rd_s_o;
    logic [XLEN-1:0]        byp_rd_v_o;
`endif

    rf_wb_arbiter_if #(.NUM_WB(2)) wb ();

    rf_wb_arbiter #(.NUM_WB(2)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wb           (wb),
        .sb_set_i     (sb_set_i),
        .sb_set_idx_i (sb_set_idx_i),
        .busy_o       (busy_o),
`ifdef ORION_WB_BYPASS_EN
        .byp_valid_o  (byp_valid_o),
        .byp_rd_s_o   (byp_rd_s_o),
        .byp_rd_v_o   (byp_rd_v_o),
`endif
        .rf_we_o      (rf_we_o),
        .rf_rd_s_o    (rf_rd_s_o),
        .rf_rd_v_o    (rf_rd_v_o)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in register file fed by the write port.
    logic [XLEN-1:0] rf_mem [NUM_REGS] = '{default: '0};
    always @(posedge clk_i) begin
        if (rf_we_o) rf_mem[rf_rd_s_o] <= rf_rd_v_o;
    end

    typedef struct packed {
        logic [RF_IDX_BITS-1:0] rd;
        logic [XLEN-1:0]        d;
    } exp_t;

    exp_t                   wr_q [$];
    int                     n_cmp = 0;
    int                     n_err = 0;
    int                     m_ptr = 0;
    logic [NUM_REGS-1:0]    m_busy = '0;
    logic                   m_we = 1'b0;
    logic [RF_IDX_BITS-1:0] m_stage_rd = '0;
    logic [1:0]             m_ready = '0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic [1:0] v,
                         input logic [4:0] r0, input logic [31:0] d0,
                         input logic [4:0] r1, input logic [31:0] d1,
                         input logic set, input logic [4:0] sidx,
                         input logic rst_mid);
        logic [4:0]  rr [2];
        logic [31:0] dd [2];
        logic [31:0] nb;
        int          g;
        exp_t        e;
        @(negedge clk_i);
        chk("rf_we", rf_we_o, m_we);
`ifdef ORION_WB_BYPASS_EN
        chk("byp_valid", byp_valid_o, m_we);
`endif
        if (m_we) begin
            e = wr_q.pop_front();
            chk("rf_rd_s", rf_rd_s_o, e.rd);
            chk("rf_rd_v", rf_rd_v_o, e.d);
`ifdef ORION_WB_BYPASS_EN
            chk("byp_rd_s", byp_rd_s_o, e.rd);
            chk("byp_rd_v", byp_rd_v_o, e.d);
`endif
        end
        chk("busy", busy_o, m_busy);
        rst_i = 1'b0;
        wb.wb_valid  = v;
        wb.wb_req[0] = '{rd_s: r0, rd_v: d0};
        wb.wb_req[1] = '{rd_s: r1, rd_v: d1};
        sb_set_i     = set;
        sb_set_idx_i = sidx;
        #1;
        rr[0] = r0; rr[1] = r1;
        dd[0] = d0; dd[1] = d1;
        g = -1;
        for (int i = 0; i < 2; i++) begin
            int k;
            k = (m_ptr + i) % 2;
            if (g < 0 && v[k] && rr[k] != 0) g = k;
        end
        m_ready = '0;
        for (int k = 0; k < 2; k++) begin
            if (v[k] && rr[k] == 0) m_ready[k] = 1'b1;
        end
        if (g >= 0) m_ready[g] = 1'b1;
        chk("ready", wb.wb_ready, m_ready);
        nb = m_busy;
`ifdef ORION_WB_BYPASS_EN
        if (g >= 0) nb[rr[g]] = 1'b0;
`else
        if (m_we) nb[m_stage_rd] = 1'b0;
`endif
        if (set) nb[sidx] = 1'b1;
        nb[0] = 1'b0;
        if (rst_mid) begin
            #2 rst_i = 1'b1;
            m_ptr  = 0;
            m_busy = '0;
            m_we   = 1'b0;
            wr_q.delete();
        end else begin
            m_busy = nb;
            m_we   = (g >= 0);
            if (g >= 0) begin
                m_stage_rd = rr[g];
                e.rd = rr[g];
                e.d  = dd[g];
                wr_q.push_back(e);
                m_ptr = (g + 1) % 2;
            end
        end
    endtask

    task automatic idle();
        cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    endtask

    logic [1:0]  cur_v;
    logic [4:0]  cur_r [2];
    logic [31:0] cur_d [2];
    logic [4:0]  rs;
    logic        rset;

    initial begin
        rst_i        = 1'b1;
        wb.wb_valid  = '0;
        wb.wb_req    = '0;
        sb_set_i     = 1'b0;
        sb_set_idx_i = '0;

        // Reset values
        @(negedge clk_i);
        chk("rst_we", rf_we_o, 1'b0);
        chk("rst_rd_s", rf_rd_s_o, 5'd0);
        chk("rst_rd_v", rf_rd_v_o, 32'd0);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_ready", wb.wb_ready, 2'b00);

        // Contention from reset: 0,1,0,1 with no bubbles
        for (int i = 0; i < 4; i++)
            cycle(2'b11, 5'd1, 32'h1111, 5'd2, 32'h2222, 1'b0, 5'd0, 1'b0);
        idle();
        idle();

        // Single request, visible in the file two cycles later
        cycle(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        idle();
        idle();
        chk("x5_mem", rf_mem[5], 32'hDEADBEEF);

        // x0 alongside a real request, then confirm pointer via contention
        cycle(2'b11, 5'd0, 32'hAAAA, 5'd7, 32'h7777, 1'b0, 5'd0, 1'b0);
        cycle(2'b11, 5'd0, 32'hBBBB, 5'd0, 32'hCCCC, 1'b0, 5'd0, 1'b0);
        cycle(2'b11, 5'd8, 32'h8888, 5'd9, 32'h9999, 1'b0, 5'd0, 1'b0);
        cycle(2'b11, 5'd8, 32'h8888, 5'd9, 32'h9999, 1'b0, 5'd0, 1'b0);
        idle();
        idle();
        chk("x7_mem", rf_mem[7], 32'h7777);

        // Scoreboard: set x3, grant its write five cycles later
        cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
        for (int i = 0; i < 4; i++) idle();
        cycle(2'b01, 5'd3, 32'h3333, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) idle();
        chk("x3_free", busy_o[3], 1'b0);

        // Set/clear collision on x9
        cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
`ifdef ORION_WB_BYPASS_EN
        cycle(2'b01, 5'd9, 32'h9A9A, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
`else
        cycle(2'b01, 5'd9, 32'h9A9A, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
`endif
        idle();
        chk("x9_set_wins", busy_o[9], 1'b1);
        cycle(2'b10, 5'd0, 32'h0, 5'd9, 32'h9B9B, 1'b0, 5'd0, 1'b0);
        idle();
        idle();

        // Random traffic, requests held until accepted
        cur_v = '0;
        cur_r[0] = '0; cur_r[1] = '0;
        cur_d[0] = '0; cur_d[1] = '0;
        for (int n = 0; n < 60; n++) begin
            rs   = 5'($urandom_range(0, 15));
            rset = ($urandom_range(0, 3) == 0) && !m_busy[rs];
            cycle(cur_v, cur_r[0], cur_d[0], cur_r[1], cur_d[1],
                  rset, rs, 1'b0);
            for (int k = 0; k < 2; k++) begin
                if (!cur_v[k] || m_ready[k]) begin
                    cur_v[k] = 1'($urandom_range(0, 1));
                    cur_r[k] = 5'($urandom_range(0, 7));
                    cur_d[k] = $urandom;
                end
            end
        end
        idle();
        idle();

        // Reset between a grant and its edge
        cycle(2'b01, 5'd4, 32'h4444, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0);
        idle();
        idle();
        chk("x4_before", rf_mem[4], 32'h4444);
        cycle(2'b01, 5'd4, 32'h9999, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
        idle();
        chk("rst_mid_busy", busy_o, 32'd0);
        idle();
        chk("x4_kept", rf_mem[4], 32'h4444);
        cycle(2'b11, 5'd1, 32'h5151, 5'd2, 32'h5252, 1'b0, 5'd0, 1'b0);
        cycle(2'b10, 5'd1, 32'h5151, 5'd2, 32'h5252, 1'b0, 5'd0, 1'b0);
        idle();
        idle();
        chk("q_drain", wr_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
